controller_reader: RTL
======================

CONTROLLER_READER -- requirements
Module: controller_reader

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 6: gpu_clk cycles per controller-clock phase (low or high).
REQ-002 SHALL have parameter LATCH_CYCLES, default 12: gpu_clk cycles the latch is held high.
REQ-003 SHALL have port gpu_clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start_fetch  input  1  fetch request from the GPU, high while hcounter<0x20 and vcounter==0.
REQ-006 SHALL have port ctrl_latch  output  1  parallel-load strobe to both controllers.
REQ-007 SHALL have port ctrl_clk  output  1  shift clock to both controllers; idles high.
REQ-008 SHALL have port ctrl_data_1, ctrl_data_2  input  1 each  serial data, active-low (0 = pressed).
REQ-009 SHALL have port SELECT_controller_1, SELECT_controller_2  input  1 each  CPU read selects.
REQ-010 SHALL have port data_out  output  8  CPU read data.
REQ-011 SHALL have port busy  output  1  high while a fetch is in progress.

Function
REQ-012 SHALL detect a fetch on a start_fetch rising edge: start_fetch=1 with registered previous value 0.
REQ-013 SHALL implement FSM states IDLE, LATCH, LOW, HIGH, DONE; busy = (state != IDLE).
REQ-014 IDLE -> LATCH on a detected edge; ctrl_latch=1 for exactly LATCH_CYCLES cycles.
REQ-015 LATCH -> LOW with bit index 0; in LOW, ctrl_clk=0 for HALF_PERIOD cycles.
REQ-016 On the last LOW cycle, SHALL sample both inverted data inputs into internal shift registers.
REQ-017 LOW -> HIGH; in HIGH, ctrl_clk=1 for HALF_PERIOD cycles; ctrl_clk rising edge advances the controllers.
REQ-018 After HIGH, SHALL go to LOW with bit index +1 if bit index < 7, else to DONE.
REQ-019 The first serial bit SHALL land in bit 7 and the eighth in bit 0 (A,B,Select,Start,Up,Down,Left,Right = 7..0).
REQ-020 DONE SHALL last one cycle, copy both shift registers to controller_1/controller_2 atomically, then go to IDLE.
REQ-021 With defaults, registers SHALL update on the 109th rising edge after the edge that first samples start_fetch high; busy high for those 109 cycles.
REQ-022 Start_fetch edges while busy SHALL be ignored, with no restart and no queueing.
REQ-023 data_out SHALL equal controller_1 if SELECT_controller_1, else controller_2 if SELECT_controller_2, else high-Z; combinational.
REQ-024 CPU reads during a fetch SHALL return the previously committed values (double-buffered).
REQ-025 Phase and bit counters SHALL be sized for the parameters; no wrap-around within a fetch.

Reset
REQ-026 rst SHALL force: state IDLE, ctrl_latch=0, ctrl_clk=1, busy=0, controller_1=controller_2=0, shift registers 0, counters 0.
REQ-027 Previous-start_fetch register SHALL reset to 1, so a window already high at reset release does not start a fetch.
REQ-028 rst mid-fetch SHALL abort with no register commit; partial data discarded.
REQ-029 rst SHALL take priority over every other event in the same cycle.

Configuration
REQ-030 Macro CONTROLLER_READER_P2_EN defined: second controller captured per REQ-016..REQ-020.
REQ-031 Macro undefined: ctrl_data_2 ignored, controller_2 held 0, SELECT_controller_2 reads 0x00; ports unchanged.

Verification
REQ-032 Controller 1 serial stream 0,1,1,1,1,1,1,0 (A and Right pressed); pulse start_fetch -> controller_1=0x81 exactly 109 cycles after edge; SELECT_controller_1 reads 0x81.
REQ-033 Edge followed by a second start_fetch edge at cycle 40 -> single fetch only: ctrl_latch pulses once and exactly 8 ctrl_clk low pulses occur.
REQ-034 Prior value 0x00, new stream all 0 -> SELECT_controller_1 reads 0x00 through cycle 108 and 0xFF from cycle 109.
REQ-035 rst asserted at cycle 50 of a fetch -> ctrl_clk=1, ctrl_latch=0, busy=0 next cycle; controller_1 = 0x00.
REQ-036 start_fetch held high through rst release -> no fetch until start_fetch goes low and high again.
REQ-037 With P2_EN, controller 2 stream yields 0x3C -> controller_2=0x3C; without P2_EN -> reads 0x00.

Source files
------------

// File: rtl/controller_reader.sv
// ============================================================================
// controller_reader : serial game-controller poller with a double-buffered
// CPU read port. Optional second controller: CONTROLLER_READER_P2_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module controller_reader #(
  parameter int HALF_PERIOD  = 6,
  parameter int LATCH_CYCLES = 12
) (
  input  logic       gpu_clk,
  input  logic       rst,
  input  logic       start_fetch,
  output logic       ctrl_latch,
  output logic       ctrl_clk,
  input  logic       ctrl_data_1,
  input  logic       ctrl_data_2,
  input  logic       SELECT_controller_1,
  input  logic       SELECT_controller_2,
  output logic [7:0] data_out,
  output logic       busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_LOW   = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int PH_MAX = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0] c_latch_last = PH_W'(LATCH_CYCLES - 1);
  localparam logic [PH_W-1:0] c_half_last  = PH_W'(HALF_PERIOD - 1);
  localparam logic [PH_W-1:0] c_phase_one  = PH_W'(1);
  localparam logic [2:0]      c_last_bit   = 3'd7;

  logic [2:0]      r_state;
  logic [2:0]      w_next_state;
  logic [PH_W-1:0] r_phase;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift_1;
  logic [7:0]      r_shift_2;
  logic [7:0]      r_controller_1;
  logic [7:0]      r_controller_2;
  logic            r_prev_start;
  logic            w_edge;
  logic            w_bit_1;
  logic            w_bit_2;

  // Controllers drive active-low data; store pressed buttons as 1.
  assign w_bit_1 = ~ctrl_data_1;

`ifdef CONTROLLER_READER_P2_EN
  assign w_bit_2 = ~ctrl_data_2;
`else
  logic w_unused;
  assign w_bit_2  = 1'b0;
  assign w_unused = ctrl_data_2;
`endif

  assign w_edge = start_fetch & ~r_prev_start;

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_edge) w_next_state = S_LATCH;
      S_LATCH: if (r_phase == c_latch_last) w_next_state = S_LOW;
      S_LOW:   if (r_phase == c_half_last) w_next_state = S_HIGH;
      S_HIGH: begin
        if (r_phase == c_half_last) begin
          w_next_state = (r_bit == c_last_bit) ? S_DONE : S_LOW;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl_latch = 1'b0;
    ctrl_clk   = 1'b1;
    busy       = 1'b1;
    case (r_state)
      S_IDLE:  busy       = 1'b0;
      S_LATCH: ctrl_latch = 1'b1;
      S_LOW:   ctrl_clk   = 1'b0;
      default: ;
    endcase
  end

  // Phase restarts on every state change, so each phase is counted from zero.
  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      r_phase        <= '0;
      r_bit          <= '0;
      r_shift_1      <= '0;
      r_shift_2      <= '0;
      r_controller_1 <= '0;
      r_controller_2 <= '0;
      r_prev_start   <= 1'b1;
    end else begin
      r_prev_start <= start_fetch;

      if (r_state != w_next_state) begin
        r_phase <= '0;
      end else if (r_state != S_IDLE) begin
        r_phase <= r_phase + c_phase_one;
      end

      if (r_state == S_LATCH) begin
        r_bit <= '0;
      end else if (r_state == S_HIGH && r_phase == c_half_last && r_bit != c_last_bit) begin
        r_bit <= r_bit + 3'd1;
      end

      if (r_state == S_LOW && r_phase == c_half_last) begin
        r_shift_1 <= {r_shift_1[6:0], w_bit_1};
        r_shift_2 <= {r_shift_2[6:0], w_bit_2};
      end

      if (r_state == S_DONE) begin
        r_controller_1 <= r_shift_1;
        r_controller_2 <= r_shift_2;
      end
    end
  end

  assign data_out = SELECT_controller_1 ? r_controller_1 :
                    SELECT_controller_2 ? r_controller_2 : 8'bz;

endmodule

`default_nettype wire
